// File: rtl/i2c_data_transfer.sv
`timescale 1ns/1ps
// I2C subordinate data-phase engine: shifts write bytes into memory and read bytes
// out of memory once the address checker has opened the data phase.
module i2c_data_transfer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       transfer_en,
  input  logic       mem_read_bit,
  input  logic       mem_write_bit,
  input  logic [7:0] mem_rdata,
  output logic       sda_oe,
  output logic       mem_rd,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic       increment_mem_address,
  output logic       nack_rcvd,
  output logic       bus_abort
);

  typedef enum logic [3:0] {
    IDLE,
    WR_DATA,
    WR_ACK_WAIT,
    WR_ACK,
    RD_FETCH,
    RD_DATA,
    RD_ACK,
    RD_WAIT_FALL,
    RD_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             fetch_cnt_q, fetch_cnt_d;
  logic                   seen_rise_q, seen_rise_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   mem_we_q, mem_we_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   inc_q, inc_d;
  logic                   nack_q, nack_d;
  logic                   abort_q, abort_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_stop;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign sda_rise   = sda_s & ~sda_prev_q;
  assign sda_fall   = ~sda_s & sda_prev_q;
  // SCL must be high on both samples so an SDA change racing an SCL edge is not a START/STOP
  assign start_stop = (sda_rise | sda_fall) & scl_s & scl_prev_q;

  always_comb begin
    state_d     = state_q;
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d  = scl_s;
    sda_prev_d  = sda_s;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    seen_rise_d = seen_rise_q;
    sda_oe_d    = sda_oe_q;
    mem_rd_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    inc_d       = 1'b0;
    nack_d      = 1'b0;
    abort_d     = 1'b0;

    if (state_q != IDLE && !transfer_en) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (state_q != IDLE && start_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      abort_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d    = 1'b0;
          bit_cnt_d   = 3'd0;
          fetch_cnt_d = 2'd0;
          seen_rise_d = 1'b0;
          if (transfer_en && mem_read_bit) begin
            state_d = RD_FETCH;
          end else if (transfer_en && mem_write_bit) begin
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = WR_ACK_WAIT;
            end
          end
        end
        WR_ACK_WAIT: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = shift_q;
            state_d     = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            inc_d    = 1'b1;
            state_d  = WR_DATA;
          end
        end
        // Strobe, let the memory register its output, then capture one clock later
        RD_FETCH: begin
          case (fetch_cnt_q)
            2'd0: begin
              mem_rd_d    = 1'b1;
              fetch_cnt_d = 2'd1;
            end
            2'd1: fetch_cnt_d = 2'd2;
            default: begin
              shift_d     = mem_rdata;
              sda_oe_d    = ~mem_rdata[7];
              bit_cnt_d   = 3'd0;
              seen_rise_d = 1'b0;
              fetch_cnt_d = 2'd0;
              state_d     = RD_DATA;
            end
          endcase
        end
        RD_DATA: begin
          if (scl_rise) begin
            seen_rise_d = 1'b1;
          end else if (scl_fall && seen_rise_q) begin
            seen_rise_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
              state_d   = RD_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              inc_d   = 1'b1;
              state_d = RD_WAIT_FALL;
            end else begin
              nack_d  = 1'b1;
              state_d = RD_DONE;
            end
          end
        end
        RD_WAIT_FALL: begin
          if (scl_fall) begin
            fetch_cnt_d = 2'd0;
            state_d     = RD_FETCH;
          end
        end
        RD_DONE: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      shift_q     <= 8'd0;
      bit_cnt_q   <= 3'd0;
      fetch_cnt_q <= 2'd0;
      seen_rise_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      inc_q       <= 1'b0;
      nack_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      seen_rise_q <= seen_rise_d;
      sda_oe_q    <= sda_oe_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      inc_q       <= inc_d;
      nack_q      <= nack_d;
      abort_q     <= abort_d;
    end
  end

  assign sda_oe                = sda_oe_q;
  assign mem_rd                = mem_rd_q;
  assign mem_we                = mem_we_q;
  assign mem_wdata             = mem_wdata_q;
  assign increment_mem_address = inc_q;
  assign nack_rcvd             = nack_q;
  assign bus_abort             = abort_q;

endmodule

// File: tb/tb_i2c_data_transfer.sv
`timescale 1ns/1ps
// Directed bench for i2c_data_transfer: an I2C master model drives SCL/SDA over an
// open-drain bus, a transaction-level scoreboard tracks expected memory/handshake events.
module tb_i2c_data_transfer;

  localparam int Q = 6;  // quarter SCL period in clk cycles (SCL = clk/24)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       master_sda = 1'b1;
  logic       transfer_en = 1'b0;
  logic       mem_read_bit = 1'b0;
  logic       mem_write_bit = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       sda_oe, mem_rd, mem_we, increment_mem_address, nack_rcvd, bus_abort;
  logic [7:0] mem_wdata;
  logic       sda_line;

  assign sda_line = master_sda & ~sda_oe;

  i2c_data_transfer #(.SYNC_STAGES(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .scl_in               (scl),
    .sda_in               (sda_line),
    .transfer_en          (transfer_en),
    .mem_read_bit         (mem_read_bit),
    .mem_write_bit        (mem_write_bit),
    .mem_rdata            (mem_rdata),
    .sda_oe               (sda_oe),
    .mem_rd               (mem_rd),
    .mem_we               (mem_we),
    .mem_wdata            (mem_wdata),
    .increment_mem_address(increment_mem_address),
    .nack_rcvd            (nack_rcvd),
    .bus_abort            (bus_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_we = 0, n_rd = 0, n_inc = 0, n_nack = 0, n_abort = 0;
  int e_we = 0, e_rd = 0, e_inc = 0, e_nack = 0, e_abort = 0;
  logic [7:0] exp_wq[$];
  logic [7:0] rd_q[$];
  logic [7:0] last_wdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory: registered read port, data valid the clock after mem_rd
  always @(posedge clk) begin
    if (mem_rd) begin
      if (rd_q.size() > 0) mem_rdata <= rd_q.pop_front();
      else mem_rdata <= 8'h00;
    end
  end

  logic p_we = 1'b0, p_rd = 1'b0, p_inc = 1'b0, p_nack = 1'b0, p_abort = 1'b0;
  logic p_oe = 1'b0, p_scl = 1'b1, p_rst = 1'b1;

  always @(negedge clk) begin
    if (mem_we) begin
      n_we++;
      last_wdata = mem_wdata;
      if (exp_wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_we_unexpected actual=0x%0h required=no_write", mem_wdata);
      end else begin
        check("mem_wdata", 32'(mem_wdata), 32'(exp_wq.pop_front()));
      end
    end
    if (mem_rd) n_rd++;
    if (increment_mem_address) n_inc++;
    if (nack_rcvd) n_nack++;
    if (bus_abort) n_abort++;
    if (mem_we || mem_rd || increment_mem_address || nack_rcvd || bus_abort)
      check("pulse_1clk", 32'({mem_we & p_we, mem_rd & p_rd, increment_mem_address & p_inc,
                               nack_rcvd & p_nack, bus_abort & p_abort}), 32'd0);
    if (scl && p_scl && transfer_en && !rst && !p_rst && !bus_abort)
      check("oe_stable_scl_high", 32'(sda_oe), 32'(p_oe));
    p_we = mem_we; p_rd = mem_rd; p_inc = increment_mem_address;
    p_nack = nack_rcvd; p_abort = bus_abort;
    p_oe = sda_oe; p_scl = scl; p_rst = rst;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: master drives b in the low phase, samples the bus mid-high
  task automatic scl_bit(input logic b, output logic s);
    wait_clk(Q); master_sda = b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); s = sda_line;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic start_xfer(input logic wr, input logic rd);
    scl = 1'b0;
    wait_clk(Q);
    mem_write_bit = wr;
    mem_read_bit  = rd;
    transfer_en   = 1'b1;
  endtask

  task automatic end_xfer();
    wait_clk(4);
    transfer_en = 1'b0; mem_write_bit = 1'b0; mem_read_bit = 1'b0;
    wait_clk(4); master_sda = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(8);
  endtask

  task automatic write_byte(input logic [7:0] b, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) exp_wq.push_back(b);
      scl_bit(b[i], s);
    end
    scl_bit(1'b1, s);
    check({name, "_ack"}, 32'(s), 32'd0);
    e_we++;
    e_inc++;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] rx);
    logic s;
    rx = 8'h00;
    e_rd++;
    for (int i = 0; i < 8; i++) begin
      scl_bit(1'b1, s);
      rx = {rx[6:0], s};
    end
    scl_bit(ack, s);
    if (ack) e_nack++;
    else e_inc++;
  endtask

  task automatic check_counts(input string name);
    wait_clk(6);
    check({name, "_we"},    32'(n_we),    32'(e_we));
    check({name, "_rd"},    32'(n_rd),    32'(e_rd));
    check({name, "_inc"},   32'(n_inc),   32'(e_inc));
    check({name, "_nack"},  32'(n_nack),  32'(e_nack));
    check({name, "_abort"}, 32'(n_abort), 32'(e_abort));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 32'({sda_oe, mem_rd, mem_we, mem_wdata, increment_mem_address,
                     nack_rcvd, bus_abort}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic       s;

    wait_clk(5);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    wait_clk(5);

    // Single write of 0xA5
    start_xfer(1'b1, 1'b0);
    write_byte(8'hA5, "wr_a5");
    end_xfer();
    check("wr_a5_data", 32'(last_wdata), 32'hA5);
    check("wr_a5_oe_after", 32'(sda_oe), 32'd0);
    check_counts("wr_a5");

    // Two back-to-back writes
    start_xfer(1'b1, 1'b0);
    write_byte(8'h3C, "wr_3c");
    write_byte(8'hFF, "wr_ff");
    end_xfer();
    check("wr_ff_data", 32'(last_wdata), 32'hFF);
    check_counts("wr2");

    // Read 0x5A (ACK) then 0xC3 (NACK)
    rd_q.push_back(8'h5A);
    rd_q.push_back(8'hC3);
    start_xfer(1'b0, 1'b1);
    read_byte(1'b0, rx);
    check("rd_byte0", 32'(rx), 32'h5A);
    read_byte(1'b1, rx);
    check("rd_byte1", 32'(rx), 32'hC3);
    wait_clk(Q);
    check("rd_done_oe", 32'(sda_oe), 32'd0);
    end_xfer();
    check_counts("rd2");

    // STOP after four write bits
    start_xfer(1'b1, 1'b0);
    scl_bit(1'b1, s);
    scl_bit(1'b0, s);
    scl_bit(1'b1, s);
    scl_bit(1'b1, s);
    wait_clk(Q); master_sda = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); master_sda = 1'b1;
    e_abort++;
    wait_clk(4);
    check("abort_oe", 32'(sda_oe), 32'd0);
    end_xfer();
    check_counts("abort");

    // Reset during the read ACK window, then a normal write
    rd_q.push_back(8'h96);
    start_xfer(1'b0, 1'b1);
    e_rd++;
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      scl_bit(1'b1, s);
      rx = {rx[6:0], s};
    end
    check("rst_rd_byte", 32'(rx), 32'h96);
    wait_clk(Q);
    check("rdack_window_oe", 32'(sda_oe), 32'd0);
    rst = 1'b1; transfer_en = 1'b0; mem_read_bit = 1'b0;
    wait_clk(1);
    check_outputs_zero("midreset_outputs");
    rst = 1'b0;
    end_xfer();
    check_counts("midreset");
    start_xfer(1'b1, 1'b0);
    write_byte(8'h01, "wr_01");
    end_xfer();
    check("wr_01_data", 32'(last_wdata), 32'h01);
    check_counts("post_rst_wr");

    // Both direction bits: read path wins
    rd_q.push_back(8'h81);
    start_xfer(1'b1, 1'b1);
    read_byte(1'b1, rx);
    check("both_rd_byte", 32'(rx), 32'h81);
    end_xfer();
    check_counts("both");

    // Hand-computed totals over the whole run
    check("total_we",    32'(n_we),    32'd4);
    check("total_rd",    32'(n_rd),    32'd4);
    check("total_inc",   32'(n_inc),   32'd5);
    check("total_nack",  32'(n_nack),  32'd2);
    check("total_abort", 32'(n_abort), 32'd1);
    check("wq_drained",  32'(exp_wq.size()), 32'd0);
    check("rdq_drained", 32'(rd_q.size()),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
